// File: rtl/b3_pkg.sv
// Shared trit definitions for the base-3 datapath: 2-bit trit type,
// its four codes, and the legality check used on load values.
package b3_pkg;

  typedef logic [1:0] trit_t;

  localparam trit_t T0 = 2'b00;
  localparam trit_t T1 = 2'b01;
  localparam trit_t T2 = 2'b10;
  localparam trit_t TX = 2'b11;

  function automatic logic trit_legal(input trit_t t);
    return (t != TX);
  endfunction

endpackage

// File: rtl/b3_incdec_cell.sv
// One ternary digit of the counter: adds or subtracts the incoming
// carry/borrow and reports the carry/borrow into the next digit.
module b3_incdec_cell
  import b3_pkg::*;
(
  input  trit_t i_trit,
  input  logic  i_cin,
  input  logic  i_up,
  output trit_t o_trit,
  output logic  o_cout
);

  always_comb begin
    o_trit = i_trit;
    o_cout = 1'b0;
    if (i_cin) begin
      if (i_up) begin
        unique case (i_trit)
          T0:      o_trit = T1;
          T1:      o_trit = T2;
          T2:      begin o_trit = T0; o_cout = 1'b1; end
          default: o_trit = T0;
        endcase
      end else begin
        unique case (i_trit)
          T0:      begin o_trit = T2; o_cout = 1'b1; end
          T1:      o_trit = T0;
          T2:      o_trit = T1;
          default: o_trit = T0;
        endcase
      end
    end
  end

endmodule

// File: rtl/b3_counter.sv
// N-trit base-3 up/down counter with checked parallel load and a
// terminal-count output that flags the cycle whose edge wraps.
module b3_counter
  import b3_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           en,
  input  logic           up,
  input  logic           load,
  input  logic [2*N-1:0] din,
  output logic [2*N-1:0] q,
  output logic           tc,
  output logic           err
);

  logic [2*N-1:0] r_q;
  logic           r_err;
  logic [2*N-1:0] w_next;
  logic [N:0]     w_carry;
  logic [N-1:0]   w_legal;
  logic           w_din_ok;

  assign w_carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_trit
    b3_incdec_cell u_cell (
      .i_trit (r_q[2*i +: 2]),
      .i_cin  (w_carry[i]),
      .i_up   (up),
      .o_trit (w_next[2*i +: 2]),
      .o_cout (w_carry[i+1])
    );
    assign w_legal[i] = trit_legal(din[2*i +: 2]);
  end

  assign w_din_ok = &w_legal;

  // Carry out of the top trit is set exactly when every trit sits at the
  // wrap value for the current direction (all 2s up, all 0s down).
  assign tc = en & ~load & w_carry[N];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_q   <= '0;
      r_err <= 1'b0;
    end else if (load) begin
      if (w_din_ok) begin
        r_q   <= din;
        r_err <= 1'b0;
      end else begin
        r_err <= 1'b1;
      end
    end else if (en) begin
      r_q <= w_next;
    end
  end

  assign q   = r_q;
  assign err = r_err;

endmodule
